icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have parameter INDEX_W, default 6, meaning line-index width (2^INDEX_W lines of 128 bits, direct-mapped).
REQ-002 The block SHALL have ports, one per line as name  direction  width  meaning:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- icache_pcin  input  32  fetch address from IFQ; bits [3:0] ignored
- icache_ren  input  1  fetch request
- icache_abort  input  1  cancel outstanding fetch response
- icache_dout  output  128  line data; word k (k=0..3) in bits [32k+31:32k]
- icache_dout_valid  output  1  one-cycle pulse, icache_dout valid
- mem_ren  output  1  one-cycle line-refill request
- mem_addr  output  32  refill address, line-aligned ({tag,index,4'b0})
- mem_rdata  input  32  refill beat data
- mem_rvalid  input  1  refill beat valid
REQ-003 The block SHALL use one clock, clk; reset SHALL be asynchronous and active-high.

Function
REQ-004 Address split SHALL be: offset [3:0], index [INDEX_W+3:4], tag [31:INDEX_W+4].
REQ-005 Per-line storage SHALL be valid bit, tag, 128-bit data.
REQ-006 FSM states SHALL be IDLE, MISS_REQ, REFILL.
REQ-007 A request SHALL be accepted only in IDLE with icache_ren=1 and icache_abort=0; icache_pcin captured at acceptance.
REQ-008 Requests in MISS_REQ or REFILL SHALL be ignored (not queued).
REQ-009 Hit (valid and tag match at acceptance) SHALL register icache_dout=line and icache_dout_valid=1 in the next cycle; state stays IDLE; a new request is acceptable every cycle (1 per cycle hit throughput).
REQ-010 Miss SHALL move to MISS_REQ; in MISS_REQ mem_ren=1 for exactly one cycle with mem_addr=captured line address; next state REFILL.
REQ-011 In REFILL each mem_rvalid=1 SHALL store mem_rdata into refill-buffer word cnt (2-bit counter from 0) and increment cnt.
REQ-012 On the beat with cnt=3 the block SHALL write data, tag, valid=1 to the indexed line, reset cnt to 0, go to IDLE, and in the following cycle drive icache_dout=assembled line with icache_dout_valid=1 unless aborted.
REQ-013 icache_abort=1 in any cycle of MISS_REQ or REFILL, or on the final beat, SHALL set a drop flag: refill completes and installs the line, but no icache_dout_valid is produced; flag cleared on return to IDLE.
REQ-014 icache_abort=1 in the cycle a hit response would be registered SHALL suppress that icache_dout_valid.
REQ-015 mem_rvalid outside REFILL SHALL be ignored.
REQ-016 icache_dout_valid SHALL be high for one cycle per response; icache_dout SHALL hold its last value otherwise.
REQ-017 mem_addr SHALL hold its value outside MISS_REQ; mem_ren SHALL be 0 outside MISS_REQ.
REQ-018 Miss latency SHALL be: acceptance T, mem_ren at T+1, icache_dout_valid one cycle after the 4th beat.

Reset
REQ-019 On reset assertion, immediately: state IDLE, all valid bits 0, cnt 0, drop flag 0, icache_dout 0, icache_dout_valid 0, mem_ren 0, mem_addr 0; tags/data need not be cleared.
REQ-020 Reset during REFILL SHALL abandon the refill without installing the line; later beats SHALL be ignored.

Verification
REQ-021 Reset, ren pcin=0x00000040 -> next cycle mem_ren=1, mem_addr=0x40; beats 0x11111111,0x22222222,0x33333333,0x44444444 -> one cycle after 4th beat dout_valid=1, dout=0x44444444_33333333_22222222_11111111.
REQ-022 Then ren pcin=0x00000048 -> dout_valid next cycle, same dout, no mem_ren; ren held 3 cycles on cached 0x40/0x48/0x4C -> 3 consecutive dout_valid pulses.
REQ-023 ren pcin=0x00000440 (index 4, tag 1) -> miss, refill replaces line; subsequent ren 0x40 -> miss with mem_addr=0x40.
REQ-024 Miss on 0x80, abort after beat 2 -> no dout_valid; after beat 4 ren 0x80 -> hit, dout_valid next cycle, no mem_ren.
REQ-025 Miss on 0xC0, reset asserted after beat 1 -> all outputs 0 immediately; remaining beats ignored; after reset ren 0x40 -> miss (valids cleared).
REQ-026 ren=1 with abort=1 in IDLE -> no acceptance, no mem_ren, no dout_valid.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped instruction cache: 2^INDEX_W lines of 128 bits, single-cycle hits,
// four-beat line refill from a 32-bit memory port with abortable responses.
module icache #(
  parameter int INDEX_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  icache_pcin,
  input  logic         icache_ren,
  input  logic         icache_abort,
  output logic [127:0] icache_dout,
  output logic         icache_dout_valid,
  output logic         mem_ren,
  output logic [31:0]  mem_addr,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_rvalid
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 28 - INDEX_W;

  typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL} state_t;

  state_t state, state_nx;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [127:0]     data_mem [LINES];
  logic [95:0]      rbuf;
  logic [1:0]       cnt;
  logic             drop;

  logic [INDEX_W-1:0] pc_index, fill_index;
  logic [TAG_W-1:0]   pc_tag, fill_tag;
  logic               accept, hit;
  logic [127:0]       fill_line;
  logic               unused_offset;

  assign pc_index      = icache_pcin[INDEX_W+3:4];
  assign pc_tag        = icache_pcin[31:INDEX_W+4];
  assign accept        = (state == IDLE) && icache_ren && !icache_abort;
  assign hit           = valid[pc_index] && (tag_mem[pc_index] == pc_tag);
  assign unused_offset = &{1'b0, icache_pcin[3:0]};

  // mem_addr doubles as the captured miss address for the install
  assign fill_index = mem_addr[INDEX_W+3:4];
  assign fill_tag   = mem_addr[31:INDEX_W+4];
  assign fill_line  = {mem_rdata, rbuf};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mem_ren  = 1'b0;
    unique case (state)
      IDLE:     if (accept && !hit) state_nx = MISS_REQ;
      MISS_REQ: begin
        mem_ren  = 1'b1;
        state_nx = REFILL;
      end
      REFILL:   if (mem_rvalid && cnt == 2'd3) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid             <= '0;
      cnt               <= '0;
      drop              <= 1'b0;
      icache_dout       <= '0;
      icache_dout_valid <= 1'b0;
      mem_addr          <= '0;
    end else begin
      icache_dout_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (hit) begin
              icache_dout       <= data_mem[pc_index];
              icache_dout_valid <= 1'b1;
            end else begin
              mem_addr <= {icache_pcin[31:4], 4'b0000};
            end
          end
        end
        MISS_REQ: if (icache_abort) drop <= 1'b1;
        REFILL: begin
          if (icache_abort) drop <= 1'b1;
          if (mem_rvalid) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              valid[fill_index] <= 1'b1;
              drop              <= 1'b0;
              if (!drop && !icache_abort) begin
                icache_dout       <= fill_line;
                icache_dout_valid <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays and the refill buffer carry no reset; the valid bits gate them
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_rvalid) begin
      unique case (cnt)
        2'd0:    rbuf[31:0]  <= mem_rdata;
        2'd1:    rbuf[63:32] <= mem_rdata;
        2'd2:    rbuf[95:64] <= mem_rdata;
        default: begin
          tag_mem[fill_index]  <= fill_tag;
          data_mem[fill_index] <= fill_line;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by randomized fetches,
// checked against a line-level model of the cache contents.
module tb_icache;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  icache_pcin;
  logic         icache_ren;
  logic         icache_abort;
  logic [127:0] icache_dout;
  logic         icache_dout_valid;
  logic         mem_ren;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_rdata;
  logic         mem_rvalid;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  bit           mvalid [64];
  logic [21:0]  mtag   [64];
  logic [127:0] mdata  [64];
  logic [127:0] exp_dout;

  icache #(.INDEX_W(6)) dut (
    .clk               (clk),
    .reset             (reset),
    .icache_pcin       (icache_pcin),
    .icache_ren        (icache_ren),
    .icache_abort      (icache_abort),
    .icache_dout       (icache_dout),
    .icache_dout_valid (icache_dout_valid),
    .mem_ren           (mem_ren),
    .mem_addr          (mem_addr),
    .mem_rdata         (mem_rdata),
    .mem_rvalid        (mem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // abort_mode: -1 none, 0 during MISS_REQ, 1..3 in a gap after that many beats, 4 with final beat
  task automatic fetch(input logic [31:0] pc, input int abort_mode,
                       input bit use_fixed, input logic [127:0] fixed_line);
    logic [5:0]   idx;
    logic [21:0]  tg;
    logic [127:0] line;
    bit           is_hit, dropped;
    idx    = pc[9:4];
    tg     = pc[31:10];
    is_hit = mvalid[idx] && (mtag[idx] == tg);
    icache_ren   = 1'b1;
    icache_pcin  = pc;
    icache_abort = 1'b0;
    mem_rvalid   = 1'($urandom_range(0, 1));
    mem_rdata    = $urandom;
    @(negedge clk);
    icache_ren = 1'b0;
    mem_rvalid = 1'b0;
    if (is_hit) begin
      exp_dout = mdata[idx];
      check("hit_valid", icache_dout_valid, 1);
      check("hit_dout", icache_dout, exp_dout);
      check("hit_no_mem_ren", mem_ren, 0);
      return;
    end
    check("miss_no_valid", icache_dout_valid, 0);
    check("miss_mem_ren", mem_ren, 1);
    check("miss_mem_addr", mem_addr, {pc[31:4], 4'h0});
    check("miss_dout_hold", icache_dout, exp_dout);
    // MISS_REQ cycle: stray beat and new request must both be ignored
    mem_rvalid   = 1'b1;
    mem_rdata    = $urandom;
    icache_ren   = 1'b1;
    icache_pcin  = $urandom;
    icache_abort = (abort_mode == 0);
    @(negedge clk);
    icache_abort = 1'b0;
    mem_rvalid   = 1'b0;
    check("mem_ren_one_cycle", mem_ren, 0);
    for (int i = 0; i < 4; i++) begin
      if (abort_mode == i && i >= 1) begin
        icache_abort = 1'b1;
        @(negedge clk);
        icache_abort = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin
        mem_rvalid  = 1'b0;
        mem_rdata   = $urandom;
        icache_ren  = 1'($urandom_range(0, 1));
        icache_pcin = $urandom;
        @(negedge clk);
      end
      mem_rvalid   = 1'b1;
      mem_rdata    = use_fixed ? fixed_line[32*i +: 32] : $urandom;
      line[32*i +: 32] = mem_rdata;
      icache_abort = (abort_mode == 4 && i == 3);
      icache_ren   = 1'($urandom_range(0, 1));
      icache_pcin  = $urandom;
      @(negedge clk);
      mem_rvalid   = 1'b0;
      icache_abort = 1'b0;
      icache_ren   = 1'b0;
      if (i < 3) check("no_early_valid", icache_dout_valid, 0);
    end
    dropped    = (abort_mode >= 0 && abort_mode <= 4);
    mvalid[idx] = 1'b1;
    mtag[idx]   = tg;
    mdata[idx]  = line;
    if (!dropped) exp_dout = line;
    check("refill_valid", icache_dout_valid, !dropped);
    check("refill_dout", icache_dout, exp_dout);
    check("refill_mem_addr_hold", mem_addr, {pc[31:4], 4'h0});
    check("refill_no_mem_ren", mem_ren, 0);
  endtask

  task automatic abort_in_idle(input logic [31:0] pc);
    icache_ren   = 1'b1;
    icache_pcin  = pc;
    icache_abort = 1'b1;
    @(negedge clk);
    icache_ren   = 1'b0;
    icache_abort = 1'b0;
    check("idle_abort_no_valid", icache_dout_valid, 0);
    check("idle_abort_no_mem_ren", mem_ren, 0);
    @(negedge clk);
    check("idle_abort_no_late_mem_ren", mem_ren, 0);
    check("idle_abort_dout_hold", icache_dout, exp_dout);
  endtask

  initial begin
    logic [31:0] pcs [3];
    reset        = 1'b1;
    icache_pcin  = '0;
    icache_ren   = 1'b0;
    icache_abort = 1'b0;
    mem_rdata    = '0;
    mem_rvalid   = 1'b0;
    exp_dout     = '0;
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_dout", icache_dout, 0);
    check("reset_dout_valid", icache_dout_valid, 0);
    check("reset_mem_ren", mem_ren, 0);
    check("reset_mem_addr", mem_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    fetch(32'h0000_0040, -1, 1'b1, 128'h44444444_33333333_22222222_11111111);
    check("directed_line", icache_dout, 128'h44444444_33333333_22222222_11111111);
    fetch(32'h0000_0048, -1, 1'b0, '0);

    pcs[0] = 32'h40; pcs[1] = 32'h48; pcs[2] = 32'h4C;
    icache_ren = 1'b1;
    for (int k = 0; k < 3; k++) begin
      icache_pcin = pcs[k];
      @(negedge clk);
      check("stream_valid", icache_dout_valid, 1);
      check("stream_dout", icache_dout, mdata[4]);
      check("stream_no_mem_ren", mem_ren, 0);
    end
    icache_ren = 1'b0;
    @(negedge clk);
    check("stream_pulse_ends", icache_dout_valid, 0);

    fetch(32'h0000_0440, -1, 1'b0, '0);
    fetch(32'h0000_0040, -1, 1'b0, '0);
    fetch(32'h0000_0080, 2, 1'b0, '0);
    fetch(32'h0000_0080, -1, 1'b0, '0);
    fetch(32'h0000_0080, 4, 1'b0, '0);
    abort_in_idle(32'h0000_0040);
    abort_in_idle(32'h0000_0100);

    // reset in the middle of a refill
    icache_ren  = 1'b1;
    icache_pcin = 32'h0000_00C0;
    @(negedge clk);
    icache_ren = 1'b0;
    check("rst_miss_mem_ren", mem_ren, 1);
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    @(negedge clk);
    mem_rvalid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_dout", icache_dout, 0);
    check("rst_mid_dout_valid", icache_dout_valid, 0);
    check("rst_mid_mem_ren", mem_ren, 0);
    check("rst_mid_mem_addr", mem_addr, 0);
    exp_dout = '0;
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("rst_late_beat_ignored", icache_dout_valid, 0);
      check("rst_late_no_mem_ren", mem_ren, 0);
    end
    fetch(32'h0000_0040, -1, 1'b0, '0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] pc;
      int mode;
      pc = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) begin
        abort_in_idle(pc);
      end else begin
        mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
        fetch(pc, mode, 1'b0, '0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
